branch_resolve: RTL and testbench

//  EX-stage branch/jump resolution, directly downstream of the branch comparator.
//  - Drives o_br_un to the comparator; consumes its less/equal flags.
//  - Compares the actual outcome with the IF prediction; registers a 1-cycle redirect and flush pulse.
//  - Squashes its own wrong-path shadow instruction.

---
 rtl/branch_resolve.sv | 154 +++++++++++++++
 tb/tb_branch_resolve.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//   EX-stage branch/jump resolution, sitting directly after the branch
//   comparator. Selects signed/unsigned compare mode, evaluates the branch
//   condition, computes the target and checks it against the IF prediction.
//   On a misprediction it registers a one-cycle redirect with a full
//   {EX,ID,IF} flush. A taken target that is not 4-byte aligned raises a
//   one-cycle misalign exception instead of a redirect. The instruction that
//   sits in EX during the flush cycle is wrong-path and is ignored (shadow).
//
// Optional feature macro: PERF_CNT_EN
//   defined   : o_br_cnt / o_mispred_cnt count resolved control transfers and
//               redirects+misaligns, wrapping mod 2^CNT_W
//   undefined : no counters are built; both outputs are tied to 0
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_stall                 pipeline stall, EX holds its instruction
//   i_ex_valid              EX holds a live instruction
//   i_ex_is_br/jal/jalr     instruction class
//   i_ex_funct3             branch funct3
//   i_ex_pc, i_ex_imm       PC and sign-extended immediate
//   i_rs1_data              forwarded rs1 (JALR base)
//   i_ex_pred_taken         IF prediction
//   i_br_less, i_br_equal   comparator flags
//   o_br_un                 unsigned compare select to the comparator
//   o_redirect, o_redirect_pc  registered redirect pulse and fetch address
//   o_flush                 registered {EX,ID,IF} kill pulse
//   o_misalign_exc          registered misaligned-target exception pulse
//   o_br_cnt, o_mispred_cnt performance counters
// -----------------------------------------------------------------------------
module branch_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_br,
    input  logic             i_ex_is_jal,
    input  logic             i_ex_is_jalr,
    input  logic [2:0]       i_ex_funct3,
    input  logic [XLEN-1:0]  i_ex_pc,
    input  logic [XLEN-1:0]  i_ex_imm,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic             i_ex_pred_taken,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    output logic             o_br_un,
    output logic             o_redirect,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic [2:0]       o_flush,
    output logic             o_misalign_exc,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    logic            shadow;
    logic            is_cf;
    logic            eval;
    logic            cond;
    logic            taken;
    logic            mispred;
    logic            misalign;
    logic            fire;
    logic            redirect_next;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;

    // BLTU/BGEU (funct3 11x) need the unsigned comparison.
    assign o_br_un = (i_ex_funct3[2:1] == 2'b11);

    always_comb begin
        cond = 1'b0;
        case (i_ex_funct3)
            3'b000:  cond = i_br_equal;
            3'b001:  cond = ~i_br_equal;
            3'b100,
            3'b110:  cond = i_br_less;
            3'b101,
            3'b111:  cond = ~i_br_less;
            default: cond = 1'b0;   // 010/011 are not branches: never taken
        endcase
    end

    assign is_cf = i_ex_is_br | i_ex_is_jal | i_ex_is_jalr;
    assign eval  = i_ex_valid & ~i_stall & ~shadow;

    // One adder serves both forms; JALR clears bit 0 of its sum.
    assign base   = i_ex_is_jalr ? i_rs1_data : i_ex_pc;
    assign sum    = base + i_ex_imm;
    assign target = i_ex_is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;

    assign taken    = i_ex_is_jal | i_ex_is_jalr | (i_ex_is_br & cond);
    // JALR has no target prediction, so it always redirects.
    assign mispred  = is_cf & (i_ex_is_jalr | (taken != i_ex_pred_taken));
    // Without compressed instructions only bit 1 can be set after JALR's bit-0 clear.
    assign misalign = taken & target[1];

    assign redirect_next = eval & mispred & ~misalign;
    assign fire          = eval & is_cf & (mispred | misalign);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_redirect     <= 1'b0;
            o_redirect_pc  <= '0;
            o_flush        <= 3'b000;
            o_misalign_exc <= 1'b0;
            shadow         <= 1'b0;
        end else begin
            o_redirect     <= redirect_next;
            o_misalign_exc <= eval & is_cf & misalign;
            o_flush        <= fire ? 3'b111 : 3'b000;
            if (fire) begin
                o_redirect_pc <= taken ? target : (i_ex_pc + XLEN'(4));
            end
            // Shadow covers the instruction in EX during the flush cycle and
            // stays up while that instruction is held by a stall.
            if (fire) begin
                shadow <= 1'b1;
            end else if (!i_stall) begin
                shadow <= 1'b0;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else begin
            if (eval && is_cf) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (fire) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign o_br_cnt      = br_cnt;
    assign o_mispred_cnt = mispred_cnt;
`else
    assign o_br_cnt      = '0;
    assign o_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
//   Directed vectors with hand-computed expectations. Each vector that must
//   produce a pulse pushes its expected {redirect, pc, flush, misalign} into a
//   queue; a monitor on the falling edge pops and compares whenever the DUT
//   shows any pulse. Counters and o_br_un are checked inline.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic             ex_valid = 1'b0;
    logic             is_br = 1'b0;
    logic             is_jal = 1'b0;
    logic             is_jalr = 1'b0;
    logic [2:0]       funct3 = 3'b000;
    logic [XLEN-1:0]  ex_pc = '0;
    logic [XLEN-1:0]  ex_imm = '0;
    logic [XLEN-1:0]  rs1 = '0;
    logic             pred = 1'b0;
    logic             less = 1'b0;
    logic             equal = 1'b0;
    logic             br_un;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [2:0]       flush;
    logic             misalign_exc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_mis = 0;

    typedef struct packed {
        logic            redirect;
        logic [XLEN-1:0] pc;
        logic [2:0]      flush;
        logic            misalign;
    } resp_t;

    resp_t exp_q[$];

    branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_ex_valid      (ex_valid),
        .i_ex_is_br      (is_br),
        .i_ex_is_jal     (is_jal),
        .i_ex_is_jalr    (is_jalr),
        .i_ex_funct3     (funct3),
        .i_ex_pc         (ex_pc),
        .i_ex_imm        (ex_imm),
        .i_rs1_data      (rs1),
        .i_ex_pred_taken (pred),
        .i_br_less       (less),
        .i_br_equal      (equal),
        .o_br_un         (br_un),
        .o_redirect      (redirect),
        .o_redirect_pc   (redirect_pc),
        .o_flush         (flush),
        .o_misalign_exc  (misalign_exc),
        .o_br_cnt        (br_cnt),
        .o_mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: any visible pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (redirect || misalign_exc || flush != 3'b000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got redirect=%0b pc=%h flush=%b misalign=%0b, required no pulse",
                         redirect, redirect_pc, flush, misalign_exc);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                if (redirect !== e.redirect || flush !== e.flush || misalign_exc !== e.misalign ||
                    (e.redirect && redirect_pc !== e.pc)) begin
                    errors++;
                    $display("FAIL pulse: got redirect=%0b pc=%h flush=%b misalign=%0b, required redirect=%0b pc=%h flush=%b misalign=%0b",
                             redirect, redirect_pc, flush, misalign_exc, e.redirect, e.pc, e.flush, e.misalign);
                end else begin
                    $display("pulse ok: redirect=%0b pc=%h flush=%b misalign=%0b",
                             redirect, redirect_pc, flush, misalign_exc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check ok %s: %h", name, act);
        end
    endtask

    task automatic check_cnt(input string name);
`ifdef PERF_CNT_EN
        check({name, "_br_cnt"},      64'(br_cnt),      64'(exp_br));
        check({name, "_mispred_cnt"}, 64'(mispred_cnt), 64'(exp_mis));
`else
        check({name, "_br_cnt"},      64'(br_cnt),      64'd0);
        check({name, "_mispred_cnt"}, 64'(mispred_cnt), 64'd0);
`endif
    endtask

    task automatic push(input logic r, input logic [XLEN-1:0] pc, input logic m);
        resp_t e;
        e.redirect = r;
        e.pc       = pc;
        e.flush    = 3'b111;
        e.misalign = m;
        exp_q.push_back(e);
    endtask

    // Drive one EX instruction for one cycle. cls: 0 none, 1 br, 2 jal, 3 jalr.
    task automatic issue(input logic v, input int cls, input logic [2:0] f3,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                         input logic [XLEN-1:0] r1, input logic p,
                         input logic lt, input logic eq, input logic st);
        ex_valid = v;
        is_br    = (cls == 1);
        is_jal   = (cls == 2);
        is_jalr  = (cls == 3);
        funct3   = f3;
        ex_pc    = pc;
        ex_imm   = imm;
        rs1      = r1;
        pred     = p;
        less     = lt;
        equal    = eq;
        stall    = st;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        issue(1'b0, 0, 3'b000, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_redirect", 64'(redirect), 64'd0);
        check("rst_pc",       64'(redirect_pc), 64'd0);
        check("rst_flush",    64'(flush), 64'd0);
        check("rst_misalign", 64'(misalign_exc), 64'd0);
        check_cnt("rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle();

        // 1: BEQ taken, predicted not-taken -> redirect to 0x140
        push(1'b1, 32'h140, 1'b0); exp_br++; exp_mis++;
        funct3 = 3'b000; #1;
        check("br_un_beq", 64'(br_un), 64'd0);
        issue(1'b1, 1, 3'b000, 32'h100, 32'h40, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();

        // 2: BLTU not taken, predicted not-taken -> nothing
        funct3 = 3'b110; #1;
        check("br_un_bltu", 64'(br_un), 64'd1);
        exp_br++;
        issue(1'b1, 1, 3'b110, 32'h200, 32'h10, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        check_cnt("bltu");

        // 3: BNE predicted taken but equal -> redirect to pc+4; shadow instr ignored
        push(1'b1, 32'h104, 1'b0); exp_br++; exp_mis++;
        issue(1'b1, 1, 3'b001, 32'h100, 32'h80, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(1'b1, 1, 3'b000, 32'h104, 32'h40, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        check_cnt("bne_shadow");

        // 4: JALR aligned then misaligned
        push(1'b1, 32'h200, 1'b0); exp_br++; exp_mis++;
        issue(1'b1, 3, 3'b000, 32'h300, 32'h0, 32'h201, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        push(1'b0, 32'h0, 1'b1); exp_br++; exp_mis++;
        issue(1'b1, 3, 3'b000, 32'h300, 32'h0, 32'h202, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // JAL correctly predicted, then JAL with negative offset mispredicted
        exp_br++;
        issue(1'b1, 2, 3'b000, 32'h400, 32'h20, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 32'h3F0, 1'b0); exp_br++; exp_mis++;
        issue(1'b1, 2, 3'b000, 32'h400, 32'hFFFF_FFF0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // BGE taken (less=0)
        push(1'b1, 32'h508, 1'b0); exp_br++; exp_mis++;
        issue(1'b1, 1, 3'b101, 32'h500, 32'h8, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // funct3=010 never taken even with equal=1
        exp_br++;
        issue(1'b1, 1, 3'b010, 32'h500, 32'h8, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Taken BEQ to a misaligned target
        push(1'b0, 32'h0, 1'b1); exp_br++; exp_mis++;
        issue(1'b1, 1, 3'b000, 32'h100, 32'h2, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();

        // Valid non-control instruction: no pulse, no count
        issue(1'b1, 0, 3'b000, 32'h800, 32'h4, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_cnt("mid");

        // 5: stall holds a taken BEQ; pulse only after stall drops
        issue(1'b1, 1, 3'b000, 32'h600, 32'h4, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(1'b1, 1, 3'b000, 32'h600, 32'h4, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        push(1'b1, 32'h604, 1'b0); exp_br++; exp_mis++;
        issue(1'b1, 1, 3'b000, 32'h600, 32'h4, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();

        // Target addition wraps mod 2^32
        push(1'b1, 32'h10, 1'b0); exp_br++; exp_mis++;
        issue(1'b1, 1, 3'b000, 32'hFFFF_FFF0, 32'h20, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        check_cnt("pre_reset");

        // Reset asserted during a pulse clears outputs immediately
        ex_valid = 1'b1; is_br = 1'b1; is_jal = 1'b0; is_jalr = 1'b0;
        funct3 = 3'b000; ex_pc = 32'h700; ex_imm = 32'h8; pred = 1'b0;
        equal = 1'b1; less = 1'b0; stall = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_redirect", 64'(redirect), 64'd1);
        check("pre_rst_pc",       64'(redirect_pc), 64'h708);
        rst_n = 1'b0;
        #1;
        check("async_rst_redirect", 64'(redirect), 64'd0);
        check("async_rst_flush",    64'(flush), 64'd0);
        check("async_rst_pc",       64'(redirect_pc), 64'd0);
        exp_br = 0; exp_mis = 0;
        check_cnt("async_rst");
        @(posedge clk);
        #2;
        idle();
        rst_n = 1'b1;
        idle();
        idle();
        check("post_rst_redirect", 64'(redirect), 64'd0);

        // Normal operation after reset
        push(1'b1, 32'h910, 1'b0); exp_br++; exp_mis++;
        issue(1'b1, 1, 3'b100, 32'h900, 32'h10, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        check_cnt("final");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
